// File: rtl/cdc_wr_arb.sv
// Round-robin write arbiter: funnels NREQ valid/ready streams into one async
// FIFO write port, granting one requester at a time for up to BURST beats.

module cdc_wr_arb_lane #(
  parameter int WIDTH = 8
) (
  input  logic             sel,
  input  logic             valid,
  input  logic             mask,
  input  logic             en,
  input  logic             full,
  input  logic [WIDTH-1:0] data,
  output logic             ready,
  output logic             xfer,
  output logic [WIDTH-1:0] dout
);
  assign ready = sel & ~full & en & ~mask;
  assign xfer  = valid & ready;
  assign dout  = xfer ? data : '0;
endmodule

module cdc_wr_arb #(
  parameter int WIDTH = 8,
  parameter int NREQ  = 4,
  parameter int BURST = 4
) (
  input  logic                  clk_a,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic [NREQ-1:0]       req_mask,
  input  logic [NREQ-1:0]       req_valid,
  input  logic [NREQ*WIDTH-1:0] req_data,
  output logic [NREQ-1:0]       req_ready,
  input  logic                  fifo_full,
  output logic                  fifo_wr_en,
  output logic [WIDTH-1:0]      fifo_din,
  output logic [NREQ-1:0]       grant,
  output logic                  busy
);
  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CW = $clog2(BURST + 1);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t            state_q, state_d;
  logic [PW-1:0]     rr_ptr_q, rr_ptr_d;
  logic [PW-1:0]     gidx_q, gidx_d;
  logic [NREQ-1:0]   grant_q, grant_d;
  logic [CW-1:0]     beat_q, beat_d;

  logic                       live;
  logic [NREQ-1:0]            sel, xfer_v, eligible;
  logic [NREQ-1:0][WIDTH-1:0] data_v, dout_v;
  logic                       found;
  logic [PW-1:0]              pick;
  int                         idx;
  logic                       owner_valid, owner_mask, release_g;
  logic [CW-1:0]              beat_inc;

  // Outputs are forced quiet while reset is held, not only after the edge.
  assign live   = rst_n & (state_q == GRANT);
  assign sel    = grant_q & {NREQ{live}};
  assign busy   = live;
  assign grant  = sel;
  assign data_v = req_data;

  for (genvar i = 0; i < NREQ; i++) begin : g_lane
    cdc_wr_arb_lane #(.WIDTH(WIDTH)) u_lane (
      .sel   (sel[i]),
      .valid (req_valid[i]),
      .mask  (req_mask[i]),
      .en    (en),
      .full  (fifo_full),
      .data  (data_v[i]),
      .ready (req_ready[i]),
      .xfer  (xfer_v[i]),
      .dout  (dout_v[i])
    );
  end

  assign fifo_wr_en = |xfer_v;

  always_comb begin
    fifo_din = '0;
    for (int i = 0; i < NREQ; i++) fifo_din = fifo_din | dout_v[i];
  end

  assign eligible = req_valid & ~req_mask & {NREQ{en}};

  // First eligible index at or above rr_ptr, wrapping.
  always_comb begin
    found = 1'b0;
    pick  = '0;
    idx   = 0;
    for (int k = 0; k < NREQ; k++) begin
      idx = int'(rr_ptr_q) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      if (!found && eligible[idx]) begin
        found = 1'b1;
        pick  = PW'(idx);
      end
    end
  end

  assign owner_valid = |(grant_q & req_valid);
  assign owner_mask  = |(grant_q & req_mask);
  assign beat_inc    = beat_q + CW'(1);
  assign release_g   = (fifo_wr_en && beat_inc == CW'(BURST)) || !owner_valid ||
                       !en || owner_mask;

  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    gidx_d   = gidx_q;
    grant_d  = grant_q;
    beat_d   = beat_q;
    case (state_q)
      IDLE: begin
        if (found) begin
          state_d = GRANT;
          gidx_d  = pick;
          grant_d = NREQ'(1) << pick;
          beat_d  = '0;
        end
      end
      GRANT: begin
        if (fifo_wr_en) beat_d = beat_inc;
        if (release_g) begin
          state_d  = IDLE;
          grant_d  = '0;
          beat_d   = '0;
          rr_ptr_d = (gidx_q == PW'(NREQ - 1)) ? '0 : gidx_q + PW'(1);
        end
      end
      default: begin
        state_d = IDLE;
        grant_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk_a) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      rr_ptr_q <= '0;
      gidx_q   <= '0;
      grant_q  <= '0;
      beat_q   <= '0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      gidx_q   <= gidx_d;
      grant_q  <= grant_d;
      beat_q   <= beat_d;
    end
  end
endmodule

// File: tb/tb_cdc_wr_arb.sv
// Bench for cdc_wr_arb: directed scenarios plus random traffic, checked against
// a transaction-level model of ownership, beat budget and per-requester streams.

module tb_cdc_wr_arb;
  localparam int WIDTH = 8;
  localparam int NREQ  = 4;
  localparam int BURST = 4;

  logic                  clk_a = 1'b0;
  logic                  rst_n;
  logic                  en;
  logic [NREQ-1:0]       req_mask;
  logic [NREQ-1:0]       req_valid;
  logic [NREQ*WIDTH-1:0] req_data;
  logic [NREQ-1:0]       req_ready;
  logic                  fifo_full;
  logic                  fifo_wr_en;
  logic [WIDTH-1:0]      fifo_din;
  logic [NREQ-1:0]       grant;
  logic                  busy;

  cdc_wr_arb #(.WIDTH(WIDTH), .NREQ(NREQ), .BURST(BURST)) dut (
    .clk_a      (clk_a),
    .rst_n      (rst_n),
    .en         (en),
    .req_mask   (req_mask),
    .req_valid  (req_valid),
    .req_data   (req_data),
    .req_ready  (req_ready),
    .fifo_full  (fifo_full),
    .fifo_wr_en (fifo_wr_en),
    .fifo_din   (fifo_din),
    .grant      (grant),
    .busy       (busy)
  );

  always #5 clk_a = ~clk_a;

  int n_tests = 0;
  int n_fail  = 0;

  // model: owner (-1 = nobody), beats used by owner, next search start
  int m_owner, m_cnt, m_ptr;
  logic [WIDTH-1:0] head [NREQ];

  // observations of DUT behaviour for directed checks
  int obs_order[$];
  int obs_beats[$];
  logic [WIDTH-1:0] obs_din[$];
  int n_wr, rdy1_cnt, stall_cnt;
  logic p_busy;
  logic [NREQ-1:0] p_grant;
  logic [NREQ-1:0] s_grant;
  logic s_busy, s_wr;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic int oh2idx(input logic [NREQ-1:0] v);
    for (int i = 0; i < NREQ; i++) if (v[i]) return i;
    return -1;
  endfunction

  task automatic clear_obs();
    obs_order.delete();
    obs_beats.delete();
    obs_din.delete();
    n_wr = 0; rdy1_cnt = 0; stall_cnt = 0;
    p_busy = 1'b0; p_grant = '0;
  endtask

  // One clock: drive data heads, check at negedge, advance model.
  task automatic tick();
    logic [NREQ-1:0]  e_rdy, e_grant;
    logic             e_wr, e_busy, x, rdy;
    logic [WIDTH-1:0] e_din;
    int g, k, j;
    for (int i = 0; i < NREQ; i++) req_data[i*WIDTH +: WIDTH] = head[i];
    @(negedge clk_a);
    e_rdy = '0; e_grant = '0; e_wr = 1'b0; e_busy = 1'b0; e_din = '0; x = 1'b0;
    g = m_owner;
    if (rst_n && g >= 0) begin
      e_grant = NREQ'(1) << g;
      e_busy  = 1'b1;
      rdy     = !fifo_full && en && !req_mask[g];
      e_rdy   = rdy ? e_grant : '0;
      x       = req_valid[g] && rdy;
      e_wr    = x;
      e_din   = x ? head[g] : '0;
    end
    chk("ready", req_ready, e_rdy);
    chk("wr_en", fifo_wr_en, e_wr);
    chk("din", fifo_din, e_din);
    chk("grant", grant, e_grant);
    chk("busy", busy, e_busy);
    chk("wr_while_full", fifo_wr_en & fifo_full, 0);

    s_grant = grant; s_busy = busy; s_wr = fifo_wr_en;
    if (busy && (!p_busy || grant != p_grant)) begin
      obs_order.push_back(oh2idx(grant));
      obs_beats.push_back(0);
    end
    if (fifo_wr_en) begin
      n_wr++;
      obs_din.push_back(fifo_din);
      if (obs_beats.size() > 0) obs_beats[obs_beats.size()-1]++;
    end
    if (req_ready[1]) rdy1_cnt++;
    if (busy && grant == 4'b0010 && fifo_full) stall_cnt++;
    p_busy = busy; p_grant = grant;

    if (!rst_n) begin
      m_owner = -1; m_cnt = 0; m_ptr = 0;
    end else if (g < 0) begin
      for (k = 0; k < NREQ; k++) begin
        j = (m_ptr + k) % NREQ;
        if (req_valid[j] && !req_mask[j] && en) begin
          m_owner = j; m_cnt = 0;
          break;
        end
      end
    end else begin
      if (x) begin
        head[g] = head[g] + 1'b1;
        m_cnt++;
      end
      if ((x && m_cnt == BURST) || !req_valid[g] || !en || req_mask[g]) begin
        m_owner = -1;
        m_ptr = (g + 1) % NREQ;
      end
    end
    @(posedge clk_a);
    #1;
  endtask

  task automatic do_reset(input int n);
    rst_n = 1'b0; req_valid = '0; req_mask = '0; fifo_full = 1'b0; en = 1'b1;
    repeat (n) tick();
    rst_n = 1'b1;
    clear_obs();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

  initial begin
    int s1_ord[5] = '{0, 1, 2, 3, 0};
    int s5_ord[4] = '{0, 2, 3, 0};
    int s2_b[3]   = '{4, 4, 2};
    logic [WIDTH-1:0] start, acc;

    m_owner = -1; m_cnt = 0; m_ptr = 0;
    for (int i = 0; i < NREQ; i++) head[i] = WIDTH'($urandom);
    req_data = '0;
    clear_obs();

    // reset state
    do_reset(2);
    chk("rst_busy", s_busy, 0);
    chk("rst_grant", s_grant, 0);
    chk("rst_wr", s_wr, 0);

    // all valid: 0,1,2,3,0, 16 writes in 20 cycles
    req_valid = 4'hF;
    repeat (20) tick();
    chk("s1_wr20", n_wr, 16);
    repeat (2) tick();
    chk("s1_ngrants", obs_order.size(), 5);
    for (int i = 0; i < 5; i++) chk("s1_order", obs_order[i], s1_ord[i]);
    for (int i = 0; i < 4; i++) chk("s1_beats", obs_beats[i], BURST);

    // only req 2, 10 beats -> 4,4,2
    do_reset(2);
    start = head[2];
    repeat (20) begin
      acc = head[2] - start;
      req_valid = (acc < 10) ? 4'b0100 : 4'b0000;
      tick();
    end
    chk("s2_ngrants", obs_order.size(), 3);
    for (int i = 0; i < 3; i++) begin
      chk("s2_owner", obs_order[i], 2);
      chk("s2_beats", obs_beats[i], s2_b[i]);
    end
    chk("s2_nwr", obs_din.size(), 10);
    for (int i = 0; i < 10; i++) chk("s2_data", obs_din[i], WIDTH'(start + WIDTH'(i)));

    // req 1 stalled by full for 5 cycles mid-burst
    do_reset(2);
    req_valid = 4'b0010;
    for (int c = 0; c < 12; c++) begin
      fifo_full = (c >= 3 && c <= 7);
      tick();
    end
    fifo_full = 1'b0;
    chk("s3_owner", obs_order[0], 1);
    chk("s3_stall", stall_cnt, 5);
    chk("s3_beats", obs_beats[0], BURST);

    // req 0 drops after 2 beats, req 3 waiting
    do_reset(2);
    start = head[0];
    repeat (12) begin
      acc = head[0] - start;
      req_valid = {1'b1, 2'b00, (acc < 2)};
      tick();
    end
    chk("s4_first", obs_order[0], 0);
    chk("s4_b0", obs_beats[0], 2);
    chk("s4_next", obs_order[1], 3);

    // req 1 masked
    do_reset(2);
    req_valid = 4'hF; req_mask = 4'b0010;
    repeat (18) tick();
    chk("s5_ngrants", obs_order.size(), 4);
    for (int i = 0; i < 4; i++) chk("s5_order", obs_order[i], s5_ord[i]);
    chk("s5_rdy1", rdy1_cnt, 0);
    req_mask = '0;

    // reset during a grant to req 2
    do_reset(2);
    req_valid = 4'b0100;
    repeat (3) tick();
    chk("s6_pre", s_grant, 4'b0100);
    rst_n = 1'b0; req_valid = 4'hF;
    tick();
    chk("s6_rst_wr", s_wr, 0);
    rst_n = 1'b1;
    clear_obs();
    tick();
    chk("s6_grant", s_grant, 0);
    chk("s6_busy", s_busy, 0);
    chk("s6_wr", s_wr, 0);
    repeat (3) tick();
    chk("s6_first", obs_order[0], 0);

    // random traffic
    do_reset(2);
    repeat (600) begin
      req_valid = NREQ'($urandom);
      req_mask  = ($urandom_range(0, 7) == 0) ? NREQ'($urandom) : '0;
      en        = ($urandom_range(0, 15) != 0);
      fifo_full = ($urandom_range(0, 3) == 0);
      rst_n     = ($urandom_range(0, 199) != 0);
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
